btn_arbiter: RTL and testbench

Four-button front-end controller that shares one debounce timer among four active-low push-buttons and applies each debounced press as a command to a 4-bit LED register. It sits between the board button pins and the LED outputs. It replaces one debounce FSM and counter per button with a single round-robin-scheduled FSM and timer. Exactly one button owns the timer at a time; the others are ignored until the owner completes its press/release cycle.

---
 rtl/btn_arbiter_if.sv | 27 ++
 rtl/btn_arbiter.sv | 124 ++++++++++++
 tb/tb_btn_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_arbiter_if.sv
// Pin-side bundle of the button arbiter: raw active-low buttons in, LED
// register and event/busy status out.
interface btn_arbiter_if;
  logic [3:0] nbtn;
  logic [3:0] led;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       busy;

  // master drives the buttons and observes the arbiter
  modport master (
    output nbtn,
    input  led,
    input  evt_valid,
    input  evt_id,
    input  busy
  );

  // slave is the arbiter itself
  modport slave (
    input  nbtn,
    output led,
    output evt_valid,
    output evt_id,
    output busy
  );
endinterface

// File: rtl/btn_arbiter.sv
// Four active-low buttons share one debounce FSM/timer under round-robin
// arbitration; each accepted press applies a command to a 4-bit LED register.
module btn_arbiter #(
  parameter int unsigned DEB_CYCLES = 2000000,
  parameter int unsigned TMR_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  btn_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEB_CYCLES - 1);

  logic [3:0]       sync1_q;
  logic [3:0]       btn_s_q;
  state_t           state_q;
  logic [1:0]       owner_q;
  logic [1:0]       last_q;
  logic [TMR_W-1:0] tmr_q;
  logic [3:0]       led_q;
  logic             evt_valid_q;
  logic [1:0]       evt_id_q;

  logic             grant_vld_d;
  logic [1:0]       grant_d;
  logic [1:0]       cand_d;
  logic [3:0]       led_d;

  // Two-flop synchronizer per pin; inverted so btn_s = 1 means pressed.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q[gi] <= 1'b0;
          btn_s_q[gi] <= 1'b0;
        end else begin
          sync1_q[gi] <= ~bus.nbtn[gi];
          btn_s_q[gi] <= sync1_q[gi];
        end
      end
    end
  endgenerate

  // Round-robin search starting after the previous grant; walking the
  // candidates from farthest to nearest lets the nearest pressed one win.
  always_comb begin
    grant_vld_d = |btn_s_q;
    grant_d     = last_q + 2'd1;
    cand_d      = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand_d = last_q + 2'(i);
      if (btn_s_q[cand_d]) begin
        grant_d = cand_d;
      end
    end
  end

  always_comb begin
    led_d = led_q;
    case (owner_q)
      2'd0:    led_d = led_q + 4'd1;
      2'd1:    led_d = led_q - 4'd1;
      2'd2:    led_d = 4'd0;
      default: led_d = ~led_q;
    endcase
  end

  // tmr only runs inside WAIT; every other path leaves it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      last_q      <= 2'd3;
      tmr_q       <= '0;
      led_q       <= 4'd0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= 2'd0;
    end else begin
      evt_valid_q <= 1'b0;
      tmr_q       <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            owner_q     <= grant_d;
            last_q      <= grant_d;
            evt_valid_q <= 1'b1;
            evt_id_q    <= grant_d;
            state_q     <= PRESS;
          end
        end
        PRESS: begin
          led_q   <= led_d;
          state_q <= WAIT;
        end
        WAIT: begin
          if (tmr_q == TMR_LAST) begin
            state_q <= RELEASE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!btn_s_q[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.led       = led_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_id    = evt_id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_btn_arbiter.sv
// Scoreboard bench for btn_arbiter: a cycle-level reference model predicts
// events, LED value and busy; a separate monitor compares against the DUT.
module tb_btn_arbiter;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_arbiter_if bus();

  btn_arbiter #(.DEB_CYCLES(D), .TMR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int         n;
    logic [1:0] id;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  // reference model state: busy window defined by grant edge arithmetic
  logic       m_busy = 1'b0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_last = 2'd3;
  logic [3:0] m_led = 4'd0;
  logic [1:0] m_evt_id = 2'd0;
  int         m_grant_n = 0;
  logic [3:0] ph [0:3] = '{default: 4'd0};

  always @(posedge clk) begin
    logic [3:0] bs;
    logic [1:0] c;
    logic       found;
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 1'b0; m_owner = 2'd0; m_last = 2'd3; m_led = 4'd0; m_evt_id = 2'd0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) ph[i] = 4'd0;
    end else begin
      // pressed state seen by the arbiter at this edge was on the pins two edges ago
      bs = ph[(cyc + 2) % 4];
      if (m_busy) begin
        if (cyc == m_grant_n + 1) begin
          case (m_owner)
            2'd0: m_led = 4'((int'(m_led) + 1) % 16);
            2'd1: m_led = 4'((int'(m_led) + 15) % 16);
            2'd2: m_led = 4'd0;
            default: m_led = 4'(15 - int'(m_led));
          endcase
        end
        if (cyc >= m_grant_n + D + 2 && !bs[m_owner]) m_busy = 1'b0;
      end else if (bs != 4'd0) begin
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          c = 2'((int'(m_last) + i) % 4);
          if (!found && bs[c]) begin
            found = 1'b1;
            m_owner = c;
          end
        end
        m_last = m_owner;
        m_evt_id = m_owner;
        m_busy = 1'b1;
        m_grant_n = cyc;
        exp_q.push_back('{n: cyc, id: m_owner});
      end
      ph[cyc % 4] = ~bus.nbtn;
    end
  end

  // monitor: samples 2 time units after each rising edge
  always @(posedge clk) begin
    ev_t e;
    #2;
    if (!rst) begin
      n_chk++;
      if (bus.led !== m_led) begin
        n_fail++;
        $display("FAIL led cyc=%0d actual=%0d required=%0d", cyc, bus.led, m_led);
      end
      n_chk++;
      if (bus.busy !== m_busy) begin
        n_fail++;
        $display("FAIL busy cyc=%0d actual=%0b required=%0b", cyc, bus.busy, m_busy);
      end
      n_chk++;
      if (bus.evt_id !== m_evt_id) begin
        n_fail++;
        $display("FAIL evt_id_hold cyc=%0d actual=%0d required=%0d", cyc, bus.evt_id, m_evt_id);
      end
      if (bus.evt_valid === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL evt_unexpected cyc=%0d actual id=%0d required none", cyc, bus.evt_id);
        end else begin
          e = exp_q.pop_front();
          if (e.n != cyc || bus.evt_id !== e.id) begin
            n_fail++;
            $display("FAIL evt cyc=%0d actual id=%0d required id=%0d at cyc=%0d",
                     cyc, bus.evt_id, e.id, e.n);
          end else begin
            $display("event cyc=%0d id=%0d", cyc, bus.evt_id);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].n <= cyc) begin
        n_chk++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL evt_missing cyc=%0d actual evt_valid=0 required id=%0d", cyc, e.id);
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    repeat (3) @(negedge clk);
    while (bus.busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL idle_timeout actual busy=1 required busy=0");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    bus.nbtn = ~m;
    repeat (hold) @(negedge clk);
    bus.nbtn = 4'hF;
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    bus.nbtn = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (bus.led !== 4'd0 || bus.evt_valid !== 1'b0 || bus.evt_id !== 2'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values actual led=%0d ev=%0b id=%0d busy=%0b required 0 0 0 0",
               bus.led, bus.evt_valid, bus.evt_id, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single bouncy press of button 0
    for (int i = 0; i < 5; i++) begin
      bus.nbtn[0] = (i % 2 == 1);
      @(negedge clk);
    end
    bus.nbtn[0] = 1'b0;
    repeat (15) @(negedge clk);
    bus.nbtn = 4'hF;
    wait_idle();

    // wrap: 16 increments then one decrement
    for (int i = 0; i < 16; i++) press(4'b0001, 3);
    press(4'b0010, 3);

    // simultaneous press from reset, staggered release in index order
    pulse_reset();
    bus.nbtn = 4'h0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (c == 14 * i + 12) bus.nbtn[i] = 1'b1;
    end
    wait_idle();

    // round robin: after a grant to 2, buttons 1 and 3 together
    press(4'b0100, 3);
    bus.nbtn = 4'b0101;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 12) bus.nbtn[3] = 1'b1;
    end
    bus.nbtn = 4'hF;
    wait_idle();

    // long hold of button 3
    press(4'b1000, 100);

    // reset four cycles into WAIT
    bus.nbtn = 4'b1101;
    t = 0;
    while (!bus.evt_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (!bus.evt_valid) begin
      n_fail++;
      $display("FAIL press_timeout actual evt_valid=0 required 1");
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.led !== 4'd0 || bus.busy !== 1'b0 || bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait actual led=%0d busy=%0b ev=%0b required 0 0 0",
               bus.led, bus.busy, bus.evt_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.nbtn = 4'hF;
    repeat (2) @(negedge clk);
    press(4'b0111, 3);

    // randomized pin activity
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) bus.nbtn = 4'($urandom);
    end
    bus.nbtn = 4'hF;
    wait_idle();
    repeat (4) @(negedge clk);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
